// File: rtl/multicycle_computer_pkg.sv
// Shared definitions for the multicycle computer controller: state encodings,
// instruction field decode, opcode classes, condition codes and ALU commands.
package multicycle_computer_pkg;

    // Controller states s0..s15; the encodings are shared with the control decoder.
    typedef enum logic [3:0] {
        S0  = 4'd0,   // Fetch
        S1  = 4'd1,   // Decode
        S2  = 4'd2,
        S3  = 4'd3,
        S4  = 4'd4,
        S5  = 4'd5,
        S6  = 4'd6,
        S7  = 4'd7,
        S8  = 4'd8,
        S9  = 4'd9,
        S10 = 4'd10,
        S11 = 4'd11,
        S12 = 4'd12,
        S13 = 4'd13,
        S14 = 4'd14,
        S15 = 4'd15   // unreachable, recovers to Fetch
    } state_e;

    // Opcode classes, INSTRUCTION[27:26]
    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;
    localparam logic [1:0] OP_ILL = 2'b11;

    // Condition codes, INSTRUCTION[31:28]
    localparam logic [3:0] COND_EQ = 4'h0;
    localparam logic [3:0] COND_NE = 4'h1;
    localparam logic [3:0] COND_CS = 4'h2;
    localparam logic [3:0] COND_CC = 4'h3;
    localparam logic [3:0] COND_MI = 4'h4;
    localparam logic [3:0] COND_PL = 4'h5;
    localparam logic [3:0] COND_VS = 4'h6;
    localparam logic [3:0] COND_VC = 4'h7;
    localparam logic [3:0] COND_HI = 4'h8;
    localparam logic [3:0] COND_LS = 4'h9;
    localparam logic [3:0] COND_GE = 4'hA;
    localparam logic [3:0] COND_LT = 4'hB;
    localparam logic [3:0] COND_GT = 4'hC;
    localparam logic [3:0] COND_LE = 4'hD;
    localparam logic [3:0] COND_AL = 4'hE;
    localparam logic [3:0] COND_NV = 4'hF;

    // Data-processing commands that alter the control flow, INSTRUCTION[24:21]
    localparam logic [3:0] CMD_MOV = 4'b1101;
    localparam logic [3:0] CMD_CMP = 4'b1010;

    // Instruction fields the controller looks at
    typedef struct packed {
        logic [3:0] cond;  // [31:28]
        logic [1:0] op;    // [27:26]
        logic       im;    // [25]
        logic [3:0] cmd;   // [24:21], bit 24 doubles as Link for branches
        logic       l;     // [20]
        logic       ind;   // [19]
    } instr_fields_t;

    function automatic instr_fields_t decode_fields(input logic [31:0] instr);
        instr_fields_t f;
        f.cond = instr[31:28];
        f.op   = instr[27:26];
        f.im   = instr[25];
        f.cmd  = instr[24:21];
        f.l    = instr[20];
        f.ind  = instr[19];
        return f;
    endfunction

endpackage

// File: rtl/multicycle_computer_cond_check.sv
// Condition-field evaluator: decides whether a 4-bit condition code is
// satisfied by the {N,Z,C,V} status flags. Purely combinational.
module multicycle_computer_cond_check
    import multicycle_computer_pkg::*;
(
    input  logic [3:0] i_cond,
    input  logic [3:0] i_flags,
    output logic       o_pass
);

    logic w_n;
    logic w_z;
    logic w_c;
    logic w_v;

    assign {w_n, w_z, w_c, w_v} = i_flags;

    // Condition table lookup
    always_comb begin
        o_pass = 1'b0;
        unique case (i_cond)
            COND_EQ: o_pass = w_z;
            COND_NE: o_pass = ~w_z;
            COND_CS: o_pass = w_c;
            COND_CC: o_pass = ~w_c;
            COND_MI: o_pass = w_n;
            COND_PL: o_pass = ~w_n;
            COND_VS: o_pass = w_v;
            COND_VC: o_pass = ~w_v;
            COND_HI: o_pass = w_c & ~w_z;
            COND_LS: o_pass = ~w_c | w_z;
            COND_GE: o_pass = (w_n == w_v);
            COND_LT: o_pass = (w_n != w_v);
            COND_GT: o_pass = ~w_z & (w_n == w_v);
            COND_LE: o_pass = w_z | (w_n != w_v);
            COND_AL: o_pass = 1'b1;
            COND_NV: o_pass = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_computer_controller_next_state.sv
// Multicycle computer controller: 4-bit state register and next-state logic
// driven by the IR fields and the ALU flags. The condition field is evaluated
// in Decode; a failing condition retires the instruction as a no-op.
// Optional retired-instruction counter: MULTICYCLE_COMPUTER_PERF_COUNTER_EN.
module multicycle_computer_controller_next_state
    import multicycle_computer_pkg::*;
#(
    parameter int unsigned COUNT_W = 32
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               stall,
    input  logic [31:0]        INSTRUCTION,
    input  logic [3:0]         FLAGS,
    output logic [3:0]         current_state,
    output logic               cond_pass,
    output logic               illegal_instr
`ifdef MULTICYCLE_COMPUTER_PERF_COUNTER_EN
    ,
    output logic [COUNT_W-1:0] retired_count
`endif
);

    if (COUNT_W == 0) begin : g_count_w_check
        $error("COUNT_W must be at least 1");
    end

    state_e        r_state;
    state_e        w_state_next;
    logic          r_illegal;
    logic          w_illegal_next;
    instr_fields_t w_f;
    logic          w_unused_instr;

    assign w_f = decode_fields(INSTRUCTION);

    // Operand/offset bits play no part in sequencing
    assign w_unused_instr = ^INSTRUCTION[18:0];

    multicycle_computer_cond_check u_cond_check (
        .i_cond  (w_f.cond),
        .i_flags (FLAGS),
        .o_pass  (cond_pass)
    );

    // Next-state and illegal-opcode detection
    always_comb begin
        w_state_next   = S0;
        w_illegal_next = 1'b0;
        unique case (r_state)
            S0: w_state_next = S1;
            S1: begin
                if (!cond_pass) begin
                    w_state_next = S0;
                end else begin
                    unique case (w_f.op)
                        OP_DP: begin
                            if (w_f.im)                  w_state_next = S8;
                            else if (w_f.ind)            w_state_next = S12;
                            else if (w_f.cmd == CMD_MOV) w_state_next = S7;
                            else                         w_state_next = S6;
                        end
                        OP_MEM: w_state_next = w_f.ind ? S9 : S2;
                        OP_BR: begin
                            if (!w_f.im)      w_state_next = S10;
                            else if (w_f.ind) w_state_next = S11;
                            else              w_state_next = S13;
                        end
                        OP_ILL: begin
                            w_state_next   = S0;
                            w_illegal_next = 1'b1;
                        end
                    endcase
                end
            end
            S2, S9:            w_state_next = w_f.l ? S3 : S5;
            S3:                w_state_next = S4;
            S4, S5:            w_state_next = S0;
            // CMP only sets flags, so it has no writeback step
            S6, S7, S8, S12:   w_state_next = (w_f.cmd == CMD_CMP) ? S0 : S14;
            S14:               w_state_next = S0;
            S10, S13:          w_state_next = S0;
            S11:               w_state_next = S13;
            S15:               w_state_next = S0;
        endcase
    end

    // State register; stall holds it
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S0;
        end else if (!stall) begin
            r_state <= w_state_next;
        end
    end

    // Illegal-opcode pulse, suppressed while stalled
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_illegal <= 1'b0;
        end else begin
            r_illegal <= stall ? 1'b0 : w_illegal_next;
        end
    end

    assign current_state = r_state;
    assign illegal_instr = r_illegal;

`ifdef MULTICYCLE_COMPUTER_PERF_COUNTER_EN
    logic               w_retire;
    logic [COUNT_W-1:0] r_retired;

    // Any return to Fetch from another state completes one instruction
    assign w_retire = (r_state != S0) && (w_state_next == S0);

    // Retired-instruction counter, wraps naturally
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_retired <= '0;
        end else if (!stall && w_retire) begin
            r_retired <= r_retired + COUNT_W'(1);
        end
    end

    assign retired_count = r_retired;
`endif

endmodule

// File: tb/tb_multicycle_computer_controller_next_state.sv
// Self-checking bench for multicycle_computer_controller_next_state.
// Expected state paths come from an instruction-class model; optional counter
// checks follow MULTICYCLE_COMPUTER_PERF_COUNTER_EN.
module tb_multicycle_computer_controller_next_state;

    localparam int unsigned CW = 4;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        stall;
    logic [31:0] INSTRUCTION;
    logic [3:0]  FLAGS;
    logic [3:0]  current_state;
    logic        cond_pass;
    logic        illegal_instr;
`ifdef MULTICYCLE_COMPUTER_PERF_COUNTER_EN
    logic [CW-1:0] retired_count;
`endif

    int          n_checks = 0;
    int          n_bad    = 0;
    int          exp_path[$];
    logic        exp_ill;
    int unsigned exp_cnt;

    always #5 clk = ~clk;

    multicycle_computer_controller_next_state #(
        .COUNT_W (CW)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .stall         (stall),
        .INSTRUCTION   (INSTRUCTION),
        .FLAGS         (FLAGS),
        .current_state (current_state),
        .cond_pass     (cond_pass),
        .illegal_instr (illegal_instr)
`ifdef MULTICYCLE_COMPUTER_PERF_COUNTER_EN
        ,
        .retired_count (retired_count)
`endif
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic check_count(input string tag);
`ifdef MULTICYCLE_COMPUTER_PERF_COUNTER_EN
        check_eq(tag, 32'(retired_count), exp_cnt % (32'd1 << CW));
`else
        if (tag.len() < 0) $display("%s", tag);
`endif
    endtask

    // Even code selects the base predicate, odd code is its inverse
    function automatic logic ref_cond(input logic [3:0] cc, input logic [3:0] fl);
        logic n, z, c, v, b;
        {n, z, c, v} = fl;
        case (cc[3:1])
            3'd0:    b = z;
            3'd1:    b = c;
            3'd2:    b = n;
            3'd3:    b = v;
            3'd4:    b = c & ~z;
            3'd5:    b = (n == v);
            3'd6:    b = ~z & (n == v);
            default: b = 1'b1;
        endcase
        return b ^ cc[0];
    endfunction

    // Path of states from Fetch up to (not including) the return to Fetch
    function automatic void build_path(input logic [31:0] ins, input logic [3:0] fl);
        logic [3:0] cmd;
        cmd = ins[24:21];
        exp_path = {0, 1};
        if (ref_cond(ins[31:28], fl)) begin
            case (ins[27:26])
                2'd0: begin
                    if (ins[25])           exp_path.push_back(8);
                    else if (ins[19])      exp_path.push_back(12);
                    else if (cmd == 4'hD)  exp_path.push_back(7);
                    else                   exp_path.push_back(6);
                    if (cmd != 4'hA) exp_path.push_back(14);
                end
                2'd1: begin
                    exp_path.push_back(ins[19] ? 9 : 2);
                    if (ins[20]) begin
                        exp_path.push_back(3);
                        exp_path.push_back(4);
                    end else begin
                        exp_path.push_back(5);
                    end
                end
                2'd2: begin
                    if (!ins[25]) begin
                        exp_path.push_back(10);
                    end else begin
                        if (ins[19]) exp_path.push_back(11);
                        exp_path.push_back(13);
                    end
                end
                default: ;
            endcase
        end
    endfunction

    // Entered and left at a falling edge with the DUT in Fetch
    task automatic run_instr(input logic [31:0] ins, input logic [3:0] fl, input int stall_pct,
                             input int stall_st, input int stall_n);
        int ns;
        build_path(ins, fl);
        INSTRUCTION = ins;
        FLAGS       = fl;
        #1;
        check_eq("cond_pass", 32'(cond_pass), 32'(ref_cond(ins[31:28], fl)));
        for (int k = 0; k < exp_path.size(); k++) begin
            check_eq("state", 32'(current_state), 32'(exp_path[k]));
            check_eq("illegal", 32'(illegal_instr), 32'(exp_ill));
            exp_ill = 1'b0;
            ns = (exp_path[k] == stall_st) ? stall_n : 0;
            if (stall_pct > 0 && $urandom_range(99) < stall_pct) ns += $urandom_range(1, 2);
            for (int s = 0; s < ns; s++) begin
                stall = 1'b1;
                @(negedge clk);
                stall = 1'b0;
                check_eq("stall_state", 32'(current_state), 32'(exp_path[k]));
                check_eq("stall_illegal", 32'(illegal_instr), 32'd0);
                check_count("stall_count");
            end
            @(negedge clk);
        end
        exp_ill = (ins[27:26] == 2'b11) && ref_cond(ins[31:28], fl);
        exp_cnt++;
        check_eq("retire_state", 32'(current_state), 32'd0);
        check_count("retire_count");
`ifdef MULTICYCLE_COMPUTER_PERF_COUNTER_EN
        if (exp_cnt == 17) check_eq("wrap17", 32'(retired_count), 32'd1);
`endif
    endtask

    initial begin
        logic [31:0] ins;
        reset_n     = 1'b0;
        stall       = 1'b0;
        INSTRUCTION = 32'h0;
        FLAGS       = 4'h0;
        exp_ill     = 1'b0;
        exp_cnt     = 0;

        // Reset values, then an asynchronous reset in the middle of s3
        @(negedge clk);
        check_eq("rst_state", 32'(current_state), 32'd0);
        check_eq("rst_illegal", 32'(illegal_instr), 32'd0);
        check_count("rst_count");
        INSTRUCTION = 32'hE5910000;
        reset_n     = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("pre_reset_s3", 32'(current_state), 32'd3);
        #2 reset_n = 1'b0;
        #1;
        check_eq("async_rst_state", 32'(current_state), 32'd0);
        check_eq("async_rst_illegal", 32'(illegal_instr), 32'd0);
        check_count("async_rst_count");
        @(negedge clk);
        check_eq("rst_hold_state", 32'(current_state), 32'd0);
        reset_n = 1'b1;

        // Directed instructions
        run_instr(32'hE0810002, 4'b0000, 0, -1, 0);  // ADD AL
        run_instr(32'h0A000004, 4'b0000, 0, -1, 0);  // BEQ, not taken
        run_instr(32'h0A000004, 4'b0100, 0, -1, 0);  // BEQ, taken
        run_instr(32'h08000004, 4'b0100, 0, -1, 0);  // branch, Im=0
        run_instr(32'hE5910000, 4'b0000, 0, 3, 3);   // LDR with 3 stall cycles in s3
        run_instr(32'hEC000000, 4'b0000, 0, -1, 0);  // op11
        run_instr(32'hE1A00001, 4'b0000, 0, -1, 0);  // MOV
        run_instr(32'hE1500001, 4'b0000, 0, -1, 0);  // CMP
        run_instr(32'hE5810000, 4'b0000, 0, -1, 0);  // STR

        // Condition sweep with the controller frozen
        stall = 1'b1;
        for (int cc = 0; cc < 16; cc++) begin
            for (int fl = 0; fl < 16; fl++) begin
                INSTRUCTION = {4'(cc), 28'h0};
                FLAGS       = 4'(fl);
                #1;
                check_eq($sformatf("cond_%0h_%0h", cc, fl), 32'(cond_pass),
                         32'(ref_cond(4'(cc), 4'(fl))));
            end
        end
        @(negedge clk);
        stall = 1'b0;
        check_eq("sweep_state", 32'(current_state), 32'd0);
        check_eq("sweep_illegal", 32'(illegal_instr), 32'd0);
        exp_ill = 1'b0;

        // Randomized instructions with random stalls
        for (int i = 0; i < 300; i++) begin
            ins = $urandom;
            if ($urandom_range(1) == 1) ins[31:28] = 4'hE;
            run_instr(ins, 4'($urandom_range(15)), 20, -1, 0);
        end

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
